// File: rtl/eject_rr_arbiter.sv
// Round-robin arbiter that shares one collector port among numReq local-port requesters.
// Optional statistics counters (GrantCount, StallCycles) are built when ARB_STATS_EN is defined.
module eject_rr_arbiter #(
   parameter int numReq    = 4,
   parameter int idxWidth  = 2,
   parameter int dataWidth = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [numReq-1:0]             ReqUpStr,
   input  logic [numReq*dataWidth-1:0]   PacketIn,
   output logic [numReq-1:0]             GntUpStr,
   output logic                          UpStrFull,
   output logic                          ReqDnStr,
   output logic [dataWidth-1:0]          PacketOut,
   input  logic                          GntDnStr,
   input  logic                          DnStrFull,
   output logic [idxWidth-1:0]           GrantIdx,
   output logic                          Busy,
   output logic [1:0]                    state_dbg,
   output logic [idxWidth-1:0]           rr_ptr
`ifdef ARB_STATS_EN
   ,
   output logic [numReq*16-1:0]          GrantCount,
   output logic [31:0]                   StallCycles
`endif
);

   // Handshake contract: upstream requesters hold ReqUpStr until they see a
   // one-cycle GntUpStr pulse; downstream, ReqDnStr stays high with PacketOut
   // stable until GntDnStr is sampled high, and GntDnStr must fall before the
   // next arbitration round starts.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      RELEASE  = 2'd2
   } state_t;

   localparam logic [idxWidth:0]   NUM_REQ_W = (idxWidth+1)'(numReq);
   localparam logic [idxWidth-1:0] LAST_IDX  = idxWidth'(numReq-1);

   state_t                 state;
   logic                   found;
   logic [idxWidth-1:0]    winner;
   logic [idxWidth:0]      cand;
   logic [dataWidth-1:0]   pkt_slice [numReq];

   for (genvar g = 0; g < numReq; g++) begin : g_slice
      assign pkt_slice[g] = PacketIn[g*dataWidth +: dataWidth];
   end

   // Search rr_ptr, rr_ptr+1, ... with wrap at numReq (not at a power of two).
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < numReq; k++) begin
         cand = {1'b0, rr_ptr} + (idxWidth+1)'(k);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (!found && ReqUpStr[cand[idxWidth-1:0]]) begin
            found  = 1'b1;
            winner = cand[idxWidth-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ReqDnStr  <= 1'b0;
         GntUpStr  <= '0;
         PacketOut <= '0;
         GrantIdx  <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!DnStrFull && found) begin
                  PacketOut <= pkt_slice[winner];
                  GrantIdx  <= winner;
                  ReqDnStr  <= 1'b1;
                  state     <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               // The packet is already latched, so a requester dropping out here does not abort.
               if (GntDnStr) begin
                  ReqDnStr <= 1'b0;
                  GntUpStr <= {{(numReq-1){1'b0}}, 1'b1} << GrantIdx;
                  rr_ptr   <= (GrantIdx == LAST_IDX) ? '0 : GrantIdx + idxWidth'(1);
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               GntUpStr <= '0;
               if (!GntDnStr) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign UpStrFull = (state != IDLE);
   assign Busy      = (state != IDLE);
   assign state_dbg = state;

`ifdef ARB_STATS_EN
   logic [15:0] grant_cnt [numReq];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < numReq; i++) begin
            grant_cnt[i] <= '0;
         end
         StallCycles <= '0;
      end else begin
         for (int i = 0; i < numReq; i++) begin
            if (GntUpStr[i] && grant_cnt[i] != 16'hFFFF) begin
               grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
         end
         if (state == IDLE && |ReqUpStr && DnStrFull) begin
            StallCycles <= StallCycles + 32'd1;
         end
      end
   end

   for (genvar g = 0; g < numReq; g++) begin : g_cnt
      assign GrantCount[g*16 +: 16] = grant_cnt[g];
   end
`endif

   a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(GntUpStr));
   a_gnt_req_excl: assert property (@(posedge clk) disable iff (reset) !(|GntUpStr && ReqDnStr));
   a_idx_range: assert property (@(posedge clk) disable iff (reset) int'(GrantIdx) < numReq);

endmodule
